chunked_addsub: RTL and testbench

- Parametrised multi-cycle adder/subtractor for the calculator datapath.
- Processes a DATA_W-bit operand pair CHUNK_W bits per cycle, LSB chunk first, with a registered carry between chunks.
- Adds carry/borrow in and out, signed overflow, subtract mode, and valid/ready handshakes on both sides.
- Sits between operand registers and the result register, for widths where a single-cycle ripple chain misses timing.

---
 rtl/chunked_addsub.sv | 134 +++++++++++++
 tb/tb_chunked_addsub.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/chunked_addsub.sv
// Multi-cycle adder/subtractor: adds a DATA_W-bit operand pair CHUNK_W bits per
// cycle, LSB chunk first, carrying between chunks through one registered bit.
module chunked_addsub #(
  parameter int DATA_W  = 64,
  parameter int CHUNK_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              sub_i,
  input  logic              carry_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] sum_o,
  output logic              carry_o,
  output logic              overflow_o,
  output logic [1:0]        dbg_state_o
);

  localparam int NUM_CHUNKS = DATA_W / CHUNK_W;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid_o and its data stay stable until ready_i is seen.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [DATA_W-1:0]  r_a;
  logic [DATA_W-1:0]  r_b;
  logic [DATA_W-1:0]  r_acc;
  logic [DATA_W-1:0]  r_sum;
  logic               r_sub;
  logic               r_carry;
  logic               r_cout;
  logic               r_ovf;
  logic [IDX_W-1:0]   r_idx;

  logic [CHUNK_W-1:0] w_a_chunk;
  logic [CHUNK_W-1:0] w_b_chunk;
  logic [CHUNK_W:0]   w_chunk_sum;
  logic [DATA_W-1:0]  w_acc_next;
  logic               w_accept;
  logic               w_last;

  assign w_last = (r_idx == IDX_W'(NUM_CHUNKS - 1));

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (valid_i) begin
          w_accept     = 1'b1;
          w_state_next = S_CALC;
        end
      end
      S_CALC: begin
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        if (ready_i) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Chunk select and write-back as explicit muxes over the chunk index.
  always_comb begin
    w_a_chunk  = '0;
    w_b_chunk  = '0;
    w_acc_next = r_acc;
    for (int k = 0; k < NUM_CHUNKS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_a_chunk = r_a[k*CHUNK_W +: CHUNK_W];
        w_b_chunk = r_b[k*CHUNK_W +: CHUNK_W];
      end
    end
    w_chunk_sum = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK_W{1'b0}}, r_carry};
    for (int k = 0; k < NUM_CHUNKS; k++) begin
      if (r_idx == IDX_W'(k)) w_acc_next[k*CHUNK_W +: CHUNK_W] = w_chunk_sum[CHUNK_W-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_sub   <= 1'b0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        // Subtraction is A + ~B + ~borrow; the borrow-out is the inverted carry.
        r_a     <= a_i;
        r_b     <= sub_i ? ~b_i : b_i;
        r_sub   <= sub_i;
        r_carry <= sub_i ? ~carry_i : carry_i;
        r_idx   <= '0;
      end else if (r_state == S_CALC) begin
        r_acc   <= w_acc_next;
        r_carry <= w_chunk_sum[CHUNK_W];
        r_idx   <= r_idx + IDX_W'(1);
        // Published outputs only change once the full result is known.
        if (w_last) begin
          r_sum  <= w_acc_next;
          r_cout <= r_sub ^ w_chunk_sum[CHUNK_W];
          r_ovf  <= (r_a[DATA_W-1] == r_b[DATA_W-1]) && (w_acc_next[DATA_W-1] != r_a[DATA_W-1]);
        end
      end
    end
  end

  assign ready_o     = (r_state == S_IDLE);
  assign valid_o     = (r_state == S_DONE);
  assign sum_o       = r_sum;
  assign carry_o     = r_cout;
  assign overflow_o  = r_ovf;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_chunked_addsub.sv
// Bench for chunked_addsub: directed corner cases plus random operations,
// checked against a plain-arithmetic reference with signed overflow detection.
module tb_chunked_addsub;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, ready_i, sub_i, carry_i;
  logic [63:0] a_i, b_i;
  logic        ready_o, valid_o, carry_o, overflow_o;
  logic [63:0] sum_o;
  logic [1:0]  dbg_state;

  logic        valid2, ready2_i, ready2_o, vout2, carry2, ovf2;
  logic [31:0] a2, b2, sum2;
  logic [1:0]  dbg_state2;

  int          total = 0;
  int          bad   = 0;
  logic [65:0] exp_q[$];

  always #5 clk = ~clk;

  chunked_addsub #(.DATA_W(64), .CHUNK_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
    .a_i(a_i), .b_i(b_i), .sub_i(sub_i), .carry_i(carry_i),
    .valid_o(valid_o), .ready_i(ready_i), .sum_o(sum_o),
    .carry_o(carry_o), .overflow_o(overflow_o), .dbg_state_o(dbg_state)
  );

  chunked_addsub #(.DATA_W(32), .CHUNK_W(32)) dut2 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid2), .ready_o(ready2_o),
    .a_i(a2), .b_i(b2), .sub_i(1'b0), .carry_i(1'b0),
    .valid_o(vout2), .ready_i(ready2_i), .sum_o(sum2),
    .carry_o(carry2), .overflow_o(ovf2), .dbg_state_o(dbg_state2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Result packed as {overflow, carry/borrow, sum}.
  task automatic model(input logic [63:0] a, input logic [63:0] b, input logic sub,
                       input logic cin, output logic [65:0] res);
    logic signed [65:0] sa, sb, sr;
    logic        [65:0] ur;
    sa = {{2{a[63]}}, a};
    sb = {{2{b[63]}}, b};
    if (sub) begin
      sr = sa - sb - 66'(cin);
      ur = {2'b00, a} - {2'b00, b} - 66'(cin);
    end else begin
      sr = sa + sb + 66'(cin);
      ur = {2'b00, a} + {2'b00, b} + 66'(cin);
    end
    res = {(sr[65:63] != 3'b000) && (sr[65:63] != 3'b111), ur[64], ur[63:0]};
  endtask

  task automatic start_op(input logic [63:0] a, input logic [63:0] b, input logic sub,
                          input logic cin);
    int          n;
    logic [65:0] r;
    n = 0;
    @(negedge clk);
    while (ready_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_accept", ready_o, 1);
    a_i = a; b_i = b; sub_i = sub; carry_i = cin; valid_i = 1'b1;
    model(a, b, sub, cin, r);
    exp_q.push_back(r);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (valid_o !== 1'b1 && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_result(input string tag);
    logic [65:0] e;
    e = '0;
    check({tag, "_queued"}, exp_q.size() > 0, 1);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    check({tag, "_valid"}, valid_o, 1);
    check({tag, "_sum"}, sum_o, e[63:0]);
    check({tag, "_carry"}, carry_o, e[64]);
    check({tag, "_ovf"}, overflow_o, e[65]);
  endtask

  task automatic finish_hs(input int delay);
    repeat (delay) @(negedge clk);
    @(negedge clk);
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    ready_i = 1'b0;
    check("idle_after_hs", {ready_o, valid_o}, 2'b10);
  endtask

  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic sub, input logic cin);
    int lat;
    start_op(a, b, sub, cin);
    wait_done(lat);
    check({tag, "_latency"}, lat, 4);
    check_result(tag);
    finish_hs($urandom_range(0, 2));
  endtask

  initial begin
    logic [65:0] e;
    int          lat;
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0; sub_i = 1'b0; carry_i = 1'b0;
    a_i = '0; b_i = '0; valid2 = 1'b0; ready2_i = 1'b0; a2 = '0; b2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_valid", valid_o, 0);
    check("rst_ready", ready_o, 1);
    check("rst_sum", sum_o, 0);
    check("rst_carry", carry_o, 0);
    check("rst_ovf", overflow_o, 0);
    check("rst_state", dbg_state, 0);

    run_op("add_word_carry", 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    run_op("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    run_op("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    run_op("sub_neg", 64'h5, 64'h7, 1'b1, 1'b0);
    run_op("sub_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0);
    run_op("add_cin", 64'h10, 64'h20, 1'b0, 1'b1);
    run_op("sub_bin", 64'h10, 64'h5, 1'b1, 1'b1);

    // Single-chunk instance: one CALC cycle.
    @(negedge clk);
    a2 = 32'hFFFF_FFFF; b2 = 32'h1; valid2 = 1'b1;
    @(posedge clk);
    #1;
    valid2 = 1'b0;
    check("w32_calc_not_valid", vout2, 0);
    @(posedge clk);
    #1;
    check("w32_latency1_valid", vout2, 1);
    check("w32_sum", sum2, 0);
    check("w32_carry", carry2, 1);
    check("w32_ovf", ovf2, 0);
    @(negedge clk);
    ready2_i = 1'b1;
    @(posedge clk);
    #1;
    ready2_i = 1'b0;
    check("w32_idle", ready2_o, 1);

    // Backpressure with request pulses during CALC and DONE.
    start_op({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      valid_i = 1'b1; a_i = {$urandom, $urandom}; b_i = {$urandom, $urandom};
      check("bp_calc_ready", ready_o, 0);
    end
    @(negedge clk);
    valid_i = 1'b0;
    wait_done(lat);
    e = (exp_q.size() > 0) ? exp_q[0] : '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      valid_i = 1'b1; a_i = {$urandom, $urandom}; sub_i = 1'($urandom);
      check("bp_hold_valid", valid_o, 1);
      check("bp_hold_ready", ready_o, 0);
      check("bp_hold_sum", sum_o, e[63:0]);
      check("bp_hold_flags", {overflow_o, carry_o}, e[65:64]);
    end
    valid_i = 1'b0;
    check_result("bp_result");
    finish_hs(0);
    run_op("after_bp", {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0);

    // Asynchronous reset after two chunks discards the operation.
    start_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", valid_o, 0);
    check("arst_ready", ready_o, 1);
    check("arst_state", dbg_state, 0);
    check("arst_sum", sum_o, 0);
    void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst", 64'h3, 64'h4, 1'b0, 1'b0);

    for (int i = 0; i < 25; i++) begin
      logic [63:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if ($urandom_range(0, 4) == 0) ra = {1'($urandom), {63{1'($urandom)}}};
      if ($urandom_range(0, 4) == 0) rb = ~ra;
      run_op("random", ra, rb, 1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
